// File: rtl/dev_reshuffler_ctrl_pkg.sv
// dev_reshuffler_ctrl_pkg: shared state encodings, CSR map and bit positions
package dev_reshuffler_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE = 2'd3;
  localparam int ADDR_CTRL = 0;
  localparam int ADDR_NUM_BEATS = 1;
  localparam int ADDR_STATUS = 2;
  localparam int ADDR_IN_CNT = 3;
  localparam int ADDR_OUT_CNT = 4;
  localparam int ADDR_CYCLE_CNT = 5;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
endpackage

// File: rtl/dev_reshuffler_ctrl_if.sv
// dev_reshuffler_ctrl_if: CSR bus, gated stream handshakes and done pulse
interface dev_reshuffler_ctrl_if #(
  parameter int RegAddrWidth = 3,
  parameter int RegDataWidth = 32
);
  logic [RegAddrWidth-1:0] csr_addr_i;
  logic [RegDataWidth-1:0] csr_wr_data_i;
  logic csr_wr_en_i;
  logic csr_req_valid_i;
  logic csr_req_ready_o;
  logic [RegDataWidth-1:0] csr_rd_data_o;
  logic csr_rsp_valid_o;
  logic csr_rsp_ready_i;
  logic s_a_valid_i;
  logic s_a_ready_o;
  logic r_a_valid_o;
  logic r_a_ready_i;
  logic r_z_valid_i;
  logic r_z_ready_o;
  logic s_z_valid_o;
  logic s_z_ready_i;
  logic done_o;
  modport slave (
    input csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
    input s_a_valid_i, r_a_ready_i, r_z_valid_i, s_z_ready_i,
    output csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o,
    output s_a_ready_o, r_a_valid_o, r_z_ready_o, s_z_valid_o, done_o
  );
  modport master (
    output csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
    output s_a_valid_i, r_a_ready_i, r_z_valid_i, s_z_ready_i,
    input csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o,
    input s_a_ready_o, r_a_valid_o, r_z_ready_o, s_z_valid_o, done_o
  );
endinterface

// File: rtl/dev_reshuffler_ctrl_csr.sv
// dev_reshuffler_ctrl_csr: CSR handshake, register decode, start/clear pulses and NUM_BEATS
module dev_reshuffler_ctrl_csr
  import dev_reshuffler_ctrl_pkg::*;
#(
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = 3,
  parameter int CntWidth = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [RegAddrWidth-1:0] addr_i,
  input  logic [RegDataWidth-1:0] wr_data_i,
  input  logic wr_en_i,
  input  logic req_valid_i,
  output logic req_ready_o,
  output logic [RegDataWidth-1:0] rd_data_o,
  output logic rsp_valid_o,
  input  logic rsp_ready_i,
  input  logic busy_i,
  input  logic done_i,
  input  logic [CntWidth-1:0] in_cnt_i,
  input  logic [CntWidth-1:0] out_cnt_i,
  input  logic [CntWidth-1:0] cycle_cnt_i,
  output logic start_o,
  output logic clear_o,
  output logic [CntWidth-1:0] num_beats_o
);
  logic acc, wr;
  logic rsp_valid_q, rsp_valid_d;
  logic [RegDataWidth-1:0] rd_data_q, rd_data_d, rdata;
  logic [CntWidth-1:0] num_beats_q, num_beats_d;
  assign req_ready_o = !rsp_valid_q | rsp_ready_i;
  assign acc = req_valid_i & req_ready_o;
  assign wr = acc & wr_en_i;
  assign start_o = wr && addr_i == RegAddrWidth'(ADDR_CTRL) && wr_data_i[CTRL_START];
  assign clear_o = wr && addr_i == RegAddrWidth'(ADDR_CTRL) && wr_data_i[CTRL_CLEAR];
  assign rsp_valid_o = rsp_valid_q;
  assign rd_data_o = rd_data_q;
  assign num_beats_o = num_beats_q;
  // read mux; CTRL, unmapped words and anything not listed read as zero
  always_comb begin
    rdata = '0;
    case (addr_i)
      RegAddrWidth'(ADDR_NUM_BEATS): rdata = RegDataWidth'(num_beats_q);
      RegAddrWidth'(ADDR_STATUS): begin
        rdata[STAT_BUSY] = busy_i;
        rdata[STAT_DONE] = done_i;
      end
      RegAddrWidth'(ADDR_IN_CNT): rdata = RegDataWidth'(in_cnt_i);
      RegAddrWidth'(ADDR_OUT_CNT): rdata = RegDataWidth'(out_cnt_i);
      RegAddrWidth'(ADDR_CYCLE_CNT): rdata = RegDataWidth'(cycle_cnt_i);
      default: rdata = '0;
    endcase
  end
  // response is captured on acceptance and held until the requester takes it
  always_comb begin
    rsp_valid_d = acc ? 1'b1 : (rsp_ready_i ? 1'b0 : rsp_valid_q);
    rd_data_d = acc ? (wr_en_i ? '0 : rdata) : rd_data_q;
    num_beats_d = (wr && addr_i == RegAddrWidth'(ADDR_NUM_BEATS) && !busy_i) ? CntWidth'(wr_data_i) : num_beats_q;
  end
  // response and NUM_BEATS registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rd_data_q <= '0;
      num_beats_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rd_data_q <= rd_data_d;
      num_beats_q <= num_beats_d;
    end
  end
endmodule

// File: rtl/dev_reshuffler_ctrl.sv
// dev_reshuffler_ctrl: job FSM gating reshuffler handshakes for exactly NUM_BEATS beats
module dev_reshuffler_ctrl
  import dev_reshuffler_ctrl_pkg::*;
#(
  parameter int RegCount = 8,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = $clog2(RegCount),
  parameter int CntWidth = 32
) (
  input logic clk_i,
  input logic rst_i,
  dev_reshuffler_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [CntWidth-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, cyc_q, cyc_d, num_beats;
  logic start, clear, go, busy, in_ok, out_ok, in_fire, out_fire, done_q, done_d;
  dev_reshuffler_ctrl_csr #(
    .RegDataWidth(RegDataWidth),
    .RegAddrWidth(RegAddrWidth),
    .CntWidth(CntWidth)
  ) u_csr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .addr_i(bus.csr_addr_i),
    .wr_data_i(bus.csr_wr_data_i),
    .wr_en_i(bus.csr_wr_en_i),
    .req_valid_i(bus.csr_req_valid_i),
    .req_ready_o(bus.csr_req_ready_o),
    .rd_data_o(bus.csr_rd_data_o),
    .rsp_valid_o(bus.csr_rsp_valid_o),
    .rsp_ready_i(bus.csr_rsp_ready_i),
    .busy_i(busy),
    .done_i(state_q == ST_DONE),
    .in_cnt_i(in_cnt_q),
    .out_cnt_i(out_cnt_q),
    .cycle_cnt_i(cyc_q),
    .start_o(start),
    .clear_o(clear),
    .num_beats_o(num_beats)
  );
  assign busy = state_q == ST_RUN || state_q == ST_DRAIN;
  assign in_ok = state_q == ST_RUN && in_cnt_q < num_beats;
  assign out_ok = busy && out_cnt_q < num_beats;
  assign bus.r_a_valid_o = bus.s_a_valid_i & in_ok;
  assign bus.s_a_ready_o = bus.r_a_ready_i & in_ok;
  assign bus.s_z_valid_o = bus.r_z_valid_i & out_ok;
  assign bus.r_z_ready_o = bus.s_z_ready_i & out_ok;
  assign bus.done_o = done_q;
  assign in_fire = bus.s_a_valid_i & bus.r_a_ready_i & in_ok;
  assign out_fire = bus.r_z_valid_i & bus.s_z_ready_i & out_ok;
  assign go = start & !clear & (state_q == ST_IDLE || state_q == ST_DONE);
  // next state and counters; clear beats start, a zero-beat job completes immediately
  always_comb begin
    in_cnt_d = in_cnt_q + CntWidth'(in_fire);
    out_cnt_d = out_cnt_q + CntWidth'(out_fire);
    cyc_d = (busy && cyc_q != '1) ? cyc_q + CntWidth'(1) : cyc_q;
    state_d = clear ? ST_IDLE
            : go ? (num_beats == '0 ? ST_DONE : ST_RUN)
            : state_q == ST_RUN ? (in_cnt_d == num_beats ? (out_cnt_d == num_beats ? ST_DONE : ST_DRAIN) : ST_RUN)
            : state_q == ST_DRAIN ? (out_cnt_d == num_beats ? ST_DONE : ST_DRAIN)
            : state_q;
    if (clear || go) begin
      in_cnt_d = '0;
      out_cnt_d = '0;
      cyc_d = '0;
    end
    done_d = !clear && state_d == ST_DONE && (state_q != ST_DONE || go);
  end
  // state, counters and done pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      cyc_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      cyc_q <= cyc_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_dev_reshuffler_ctrl.sv
// tb_dev_reshuffler_ctrl: directed and random stimulus against a job-level reference model
module tb_dev_reshuffler_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dev_reshuffler_ctrl_if #(.RegAddrWidth(3), .RegDataWidth(32)) bus ();
  dev_reshuffler_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0, errors = 0;
  int p_sa = 0, p_ra = 0, p_rz = 0, p_sz = 0;
  int n_in = 0, n_out = 0, n_done = 0, n_gate = 0;
  bit m_valid = 0, m_act = 0, m_done = 0, m_pulse = 0, m_rv = 0;
  bit prev_act, iok, ook, acc, wr, inf, outf;
  int unsigned m_nb = 0, m_ins = 0, m_outs = 0, m_cyc = 0;
  logic [31:0] m_rd = 0, rdv, wd;
  int a;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference model: a job is active until both beat counts reach NUM_BEATS
  always @(negedge clk) begin
    iok = m_act && m_ins < m_nb;
    ook = m_act && m_outs < m_nb;
    if (m_valid) begin
      chk("r_a_valid", 32'(bus.r_a_valid_o), 32'(bus.s_a_valid_i & iok));
      chk("s_a_ready", 32'(bus.s_a_ready_o), 32'(bus.r_a_ready_i & iok));
      chk("s_z_valid", 32'(bus.s_z_valid_o), 32'(bus.r_z_valid_i & ook));
      chk("r_z_ready", 32'(bus.r_z_ready_o), 32'(bus.s_z_ready_i & ook));
      chk("req_ready", 32'(bus.csr_req_ready_o), 32'(!m_rv || bus.csr_rsp_ready_i));
      chk("rsp_valid", 32'(bus.csr_rsp_valid_o), 32'(m_rv));
      chk("rd_data", bus.csr_rd_data_o, m_rd);
      chk("done", 32'(bus.done_o), 32'(m_pulse));
      n_in += int'(bus.r_a_valid_o & bus.r_a_ready_i);
      n_out += int'(bus.s_z_valid_o & bus.s_z_ready_i);
      n_done += int'(bus.done_o);
      n_gate += int'(bus.r_a_valid_o | bus.s_a_ready_o | bus.s_z_valid_o | bus.r_z_ready_o);
    end
    if (rst) begin
      m_valid = 1; m_act = 0; m_done = 0; m_pulse = 0; m_rv = 0; m_rd = 0;
      m_nb = 0; m_ins = 0; m_outs = 0; m_cyc = 0;
    end else if (m_valid) begin
      a = int'(bus.csr_addr_i);
      wd = bus.csr_wr_data_i;
      acc = bus.csr_req_valid_i && (!m_rv || bus.csr_rsp_ready_i);
      wr = acc && bus.csr_wr_en_i;
      inf = bus.s_a_valid_i && bus.r_a_ready_i && iok;
      outf = bus.r_z_valid_i && bus.s_z_ready_i && ook;
      rdv = a == 1 ? m_nb : a == 2 ? {30'd0, m_done, m_act} : a == 3 ? m_ins
          : a == 4 ? m_outs : a == 5 ? m_cyc : 32'd0;
      if (acc) m_rd = wr ? 32'd0 : rdv;
      m_rv = acc ? 1'b1 : (bus.csr_rsp_ready_i ? 1'b0 : m_rv);
      m_pulse = 0;
      prev_act = m_act;
      if (m_act && m_cyc != 32'hFFFF_FFFF) m_cyc++;
      m_ins += inf;
      m_outs += outf;
      if (wr && a == 1 && !prev_act) m_nb = wd;
      if (wr && a == 0 && wd[1]) begin
        m_act = 0; m_done = 0; m_ins = 0; m_outs = 0; m_cyc = 0;
      end else if (wr && a == 0 && wd[0] && !prev_act) begin
        m_act = 1; m_done = 0; m_ins = 0; m_outs = 0; m_cyc = 0;
      end
      if (m_act && m_ins == m_nb && m_outs == m_nb) begin
        m_act = 0; m_done = 1; m_pulse = 1;
      end
    end
  end
  // stream-side stimulus driven by percentage knobs
  initial forever begin
    tick();
    bus.s_a_valid_i = $urandom_range(99) < p_sa;
    bus.r_a_ready_i = $urandom_range(99) < p_ra;
    bus.r_z_valid_i = $urandom_range(99) < p_rz;
    bus.s_z_ready_i = $urandom_range(99) < p_sz;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic csr_op(input int addr, input logic w, input logic [31:0] d, output logic [31:0] r);
    bus.csr_addr_i = 3'(addr);
    bus.csr_wr_en_i = w;
    bus.csr_wr_data_i = d;
    bus.csr_req_valid_i = 1'b1;
    bus.csr_rsp_ready_i = 1'b1;
    tick();
    bus.csr_req_valid_i = 1'b0;
    @(negedge clk);
    r = bus.csr_rd_data_o;
    tick();
  endtask
  task automatic csr_wr(input int addr, input logic [31:0] d);
    logic [31:0] r;
    csr_op(addr, 1'b1, d, r);
  endtask
  task automatic csr_rd_chk(input string name, input int addr, input logic [31:0] exp);
    logic [31:0] r;
    csr_op(addr, 1'b0, 32'd0, r);
    chk(name, r, exp);
  endtask
  task automatic wait_done(input int snap, input int lim);
    int n;
    n = 0;
    while (n_done <= snap && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL done_timeout: got no done pulse expected one within %0d cycles", lim);
    end
    tick();
  endtask
  initial begin
    int s_in, s_out, s_done, s_gate, n;
    logic [31:0] got[$];
    bus.csr_addr_i = '0; bus.csr_wr_data_i = '0; bus.csr_wr_en_i = 1'b0;
    bus.csr_req_valid_i = 1'b0; bus.csr_rsp_ready_i = 1'b1;
    bus.s_a_valid_i = 1'b0; bus.r_a_ready_i = 1'b0; bus.r_z_valid_i = 1'b0; bus.s_z_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_done", 32'(bus.done_o), 32'd0);
    chk("reset_rsp_valid", 32'(bus.csr_rsp_valid_o), 32'd0);
    tick();
    csr_rd_chk("reset_num_beats", 1, 32'd0);
    // four beats with everything flowing
    p_sa = 100; p_ra = 100; p_rz = 100; p_sz = 100;
    csr_wr(1, 32'd4);
    s_in = n_in; s_out = n_out; s_done = n_done;
    csr_wr(0, 32'd1);
    wait_done(s_done, 100);
    repeat (3) tick();
    chk("t1_in_beats", 32'(n_in - s_in), 32'd4);
    chk("t1_out_beats", 32'(n_out - s_out), 32'd4);
    chk("t1_done_once", 32'(n_done - s_done), 32'd1);
    csr_rd_chk("t1_status", 2, 32'd2);
    csr_rd_chk("t1_in_cnt", 3, 32'd4);
    csr_rd_chk("t1_out_cnt", 4, 32'd4);
    csr_rd_chk("t1_cycle_cnt", 5, 32'd4);
    csr_rd_chk("t1_ctrl_reads_zero", 0, 32'd0);
    // output side stalled so the job drains
    p_sz = 0;
    csr_wr(1, 32'd3);
    s_done = n_done;
    csr_wr(0, 32'd1);
    repeat (10) tick();
    @(negedge clk);
    chk("t2_in_stalled", 32'(bus.s_a_ready_o), 32'd0);
    p_sz = 100;
    wait_done(s_done, 100);
    csr_rd_chk("t2_in_cnt", 3, 32'd3);
    csr_rd_chk("t2_out_cnt", 4, 32'd3);
    csr_rd_chk("t2_status", 2, 32'd2);
    // zero-beat job
    csr_wr(1, 32'd0);
    s_done = n_done; s_gate = n_gate;
    csr_wr(0, 32'd1);
    repeat (3) tick();
    chk("t3_done_once", 32'(n_done - s_done), 32'd1);
    chk("t3_no_gating", 32'(n_gate - s_gate), 32'd0);
    csr_rd_chk("t3_status", 2, 32'd2);
    // clear mid-run, NUM_BEATS write while busy is dropped
    p_sa = 0;
    csr_wr(1, 32'd8);
    s_done = n_done;
    csr_wr(0, 32'd1);
    p_sa = 100;
    n = 0;
    while (m_ins < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick();
    p_sa = 0;
    csr_wr(1, 32'd1);
    csr_wr(0, 32'd2);
    csr_rd_chk("t4_num_beats_kept", 1, 32'd8);
    csr_rd_chk("t4_status_idle", 2, 32'd0);
    csr_rd_chk("t4_in_cnt_cleared", 3, 32'd0);
    chk("t4_no_done", 32'(n_done - s_done), 32'd0);
    // CSR backpressure with three reads in flight
    p_sa = 100;
    csr_wr(1, 32'd5);
    s_done = n_done;
    csr_wr(0, 32'd1);
    wait_done(s_done, 100);
    bus.csr_rsp_ready_i = 1'b0; bus.csr_wr_en_i = 1'b0;
    bus.csr_req_valid_i = 1'b1; bus.csr_addr_i = 3'd1;
    tick();
    bus.csr_addr_i = 3'd2;
    repeat (2) begin
      @(negedge clk);
      chk("t5_req_ready_low", 32'(bus.csr_req_ready_o), 32'd0);
      chk("t5_data_held", bus.csr_rd_data_o, 32'd5);
      tick();
    end
    bus.csr_rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.csr_rsp_valid_o) got.push_back(bus.csr_rd_data_o);
      tick();
      if (i == 0) bus.csr_addr_i = 3'd3;
      if (i == 1) bus.csr_req_valid_i = 1'b0;
    end
    chk("t5_rsp_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("t5_rsp0", got[0], 32'd5);
      chk("t5_rsp1", got[1], 32'd2);
      chk("t5_rsp2", got[2], 32'd5);
    end
    // reset in the middle of a job
    p_sa = 100; p_ra = 100; p_rz = 100; p_sz = 100;
    csr_wr(1, 32'd8);
    s_done = n_done;
    csr_wr(0, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_r_a_valid", 32'(bus.r_a_valid_o), 32'd0);
    chk("t6_s_a_ready", 32'(bus.s_a_ready_o), 32'd0);
    chk("t6_s_z_valid", 32'(bus.s_z_valid_o), 32'd0);
    chk("t6_r_z_ready", 32'(bus.r_z_ready_o), 32'd0);
    tick();
    csr_rd_chk("t6_num_beats", 1, 32'd0);
    csr_rd_chk("t6_status", 2, 32'd0);
    chk("t6_no_done", 32'(n_done - s_done), 32'd0);
    // random traffic on both the CSR bus and the streams
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        p_sa = $urandom_range(100); p_ra = $urandom_range(100);
        p_rz = $urandom_range(100); p_sz = $urandom_range(100);
      end
      a = $urandom_range(7);
      bus.csr_addr_i = 3'(a);
      bus.csr_req_valid_i = $urandom_range(2) == 0;
      bus.csr_wr_en_i = $urandom_range(1) == 1;
      bus.csr_wr_data_i = a == 0 ? ($urandom_range(15) == 0 ? 32'd2 : 32'd1)
                        : a == 1 ? 32'($urandom_range(11)) : $urandom;
      bus.csr_rsp_ready_i = $urandom_range(3) != 0;
      rst = $urandom_range(499) == 0;
      tick();
    end
    rst = 1'b0;
    bus.csr_req_valid_i = 1'b0;
    bus.csr_rsp_ready_i = 1'b1;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dev_reshuffler_ctrl.md
Name: dev_reshuffler_ctrl

Overview:
Job controller placed between the streamers and the dev_reshuffler datapath.
- Software programs a beat count over the CSR manager interface, then starts a job.
- The controller gates the reshuffler's input and output valid/ready handshakes so that exactly NUM_BEATS beats enter and leave.
- It tracks progress and cycles, and raises a one-cycle done pulse when the job completes.

Parameters:
- RegCount, 8, number of CSR words.
- RegDataWidth, 32, CSR data width.
- RegAddrWidth, $clog2(RegCount), CSR address width.
- CntWidth, 32, width of the beat and cycle counters (must be <= RegDataWidth).

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset. Synchronous, active-high.
- csr_addr_i in RegAddrWidth: CSR word address.
- csr_wr_data_i in RegDataWidth: write data.
- csr_wr_en_i in 1: 1 = write, 0 = read.
- csr_req_valid_i in 1 / csr_req_ready_o out 1: request handshake.
- csr_rd_data_o out RegDataWidth: response data.
- csr_rsp_valid_o out 1 / csr_rsp_ready_i in 1: response handshake.
- s_a_valid_i in 1 / s_a_ready_o out 1: input stream from the streamer.
- r_a_valid_o out 1 / r_a_ready_i in 1: input stream to the reshuffler.
- r_z_valid_i in 1 / r_z_ready_o out 1: output stream from the reshuffler.
- s_z_valid_o out 1 / s_z_ready_i in 1: output stream to the streamer.
- done_o out 1: one-cycle pulse on job completion.

Behaviour:
Reset:
- State IDLE; all counters 0; NUM_BEATS 0.
- csr_rsp_valid_o=0, csr_rd_data_o=0, done_o=0.
- All gated valid/ready outputs 0.
- Reset mid-job aborts immediately; no done pulse.

States and transitions:
- IDLE -> RUN on start.
- RUN -> DRAIN when in_cnt reaches NUM_BEATS.
- DRAIN -> DONE when out_cnt reaches NUM_BEATS.
- RUN -> DONE directly if the last input beat and the last output beat fire in the same cycle.
- DONE -> RUN on start. Counters are cleared on entering RUN.
- Start with NUM_BEATS=0 goes to DONE on the next cycle and pulses done_o.
- Start while in RUN or DRAIN is ignored.
- Clear (CTRL bit1) from any state -> IDLE, counters cleared, no done pulse. Clear wins over start when both are written in one word.

Gating (combinational):
- in_ok = (RUN) and in_cnt < NUM_BEATS.
- r_a_valid_o = s_a_valid_i & in_ok.
- s_a_ready_o = r_a_ready_i & in_ok.
- out_ok = (RUN or DRAIN) and out_cnt < NUM_BEATS.
- s_z_valid_o = r_z_valid_i & out_ok.
- r_z_ready_o = s_z_ready_i & out_ok.
- Data does not pass through this block.

Counters:
- in_cnt increments on each r_a_valid_o & r_a_ready_i.
- out_cnt increments on each s_z_valid_o & s_z_ready_i.
- cycle_cnt increments every cycle spent in RUN or DRAIN, saturating at all-ones.
- done_o is high for exactly the cycle after the transition into DONE is taken, i.e. the first cycle in DONE.

CSR map:
- 0 CTRL: write-only; reads return 0. bit0 = start, bit1 = clear.
- 1 NUM_BEATS: read/write. Writes in RUN or DRAIN are dropped but still acknowledged.
- 2 STATUS: read-only. bit0 = busy (RUN or DRAIN), bit1 = done (DONE).
- 3 IN_CNT, 4 OUT_CNT, 5 CYCLE_CNT: read-only, zero-extended.
- 6, 7: read 0, writes ignored.

CSR protocol:
- csr_req_ready_o = !csr_rsp_valid_o | csr_rsp_ready_i.
- An accepted request (reads and writes alike) produces csr_rsp_valid_o on the next cycle.
- csr_rsp_valid_o and data are held stable until csr_rsp_ready_i.
- Writes return 0.
- A write takes effect in the cycle the request is accepted; its state change is visible the next cycle.
- A read returns values sampled at acceptance.
- Back-to-back requests are sustained at 1 per cycle when csr_rsp_ready_i=1.

Decomposition:
Package dev_reshuffler_ctrl_pkg contains:
- State enum (IDLE, RUN, DRAIN, DONE).
- CSR address localparams: CTRL=0, NUM_BEATS=1, STATUS=2, IN_CNT=3, OUT_CNT=4, CYCLE_CNT=5.
- Bit indices: START=0, CLEAR=1, BUSY=0, DONE=1.

Sub-module dev_reshuffler_ctrl_csr owns:
- CSR handshake and response register.
- Register decode.
It emits start/clear pulses and the NUM_BEATS value. The FSM, counters and gating stay in the top module.

Test Plan:
1. Write NUM_BEATS=4, start, continuous valid and ready on both sides (zero-latency datapath) -> exactly 4 beats pass on each side. Beats 5+ are stalled (s_a_ready_o=0). done_o pulses once. STATUS=0b10. IN_CNT=OUT_CNT=4.
2. NUM_BEATS=3 with input accepted fast, output ready low for 10 cycles -> DRAIN entered after 3 inputs, s_a_ready_o=0 thereafter. DONE reached 1 cycle after the 3rd output fires. CYCLE_CNT matches the counted cycles.
3. Start with NUM_BEATS=0 -> DONE and done_o one cycle later. No gated valid/ready is ever asserted.
4. In RUN after 2 of 8 beats: write NUM_BEATS=1, then CTRL clear -> NUM_BEATS still reads 8. State IDLE, counters 0, no done_o.
5. CSR backpressure: 3 back-to-back reads with csr_rsp_ready_i=0 for 2 cycles -> csr_req_ready_o=0 while the response is held. Data is unchanged until accepted. Responses arrive in order.
6. Assert rst_i for one cycle mid-RUN -> next cycle all outputs 0, state IDLE, NUM_BEATS 0.
